// File: rtl/velocity_cell_ctrl_pkg.sv
// Shared MD cell-memory definitions: default geometry of the velocity cell RAM
// and the state encoding of the velocity scan controller.
package velocity_cell_ctrl_pkg;

    localparam int DEF_DATA_WIDTH   = 96;
    localparam int DEF_ADDR_WIDTH   = 8;
    localparam int DEF_PARTICLE_NUM = 220;
    localparam int DEF_WR_BURST_MAX = 4;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_CNT   = 3'd1,
        S_WAIT_CNT = 3'd2,
        S_SCAN     = 3'd3,
        S_DRAIN    = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    // Word 0 of the cell holds the particle count; never scan past the last slot.
    function automatic int unsigned clamp_count(input int unsigned raw, input int unsigned max_idx);
        return (raw > max_idx) ? max_idx : raw;
    endfunction

endpackage

// File: rtl/velocity_cell_ctrl_if.sv
// Bundle of the scan-control, motion-update write, scan-stream and RAM-side
// signals of the velocity cell controller.
interface velocity_cell_ctrl_if
    import velocity_cell_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) ();

    logic                  start;
    logic                  busy;
    logic                  done;

    // Write port: a word transfers in any cycle where wr_valid & wr_ready are both
    // high; wr_ready is the combinational arbiter grant and may drop while valid.
    logic                  wr_valid;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_ready;

    logic                  out_valid;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic [DATA_WIDTH-1:0] out_data;

    logic [ADDR_WIDTH-1:0] particle_count;
    logic                  wr_err;

    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  mem_rden;
    logic                  mem_wren;
    logic [DATA_WIDTH-1:0] mem_q;

    modport slave (
        input  start, wr_valid, wr_addr, wr_data, mem_q,
        output busy, done, wr_ready, out_valid, out_addr, out_data,
               particle_count, wr_err, mem_address, mem_data, mem_rden, mem_wren
    );

    modport master (
        output start, wr_valid, wr_addr, wr_data, mem_q,
        input  busy, done, wr_ready, out_valid, out_addr, out_data,
               particle_count, wr_err, mem_address, mem_data, mem_rden, mem_wren
    );

endinterface

// File: rtl/velocity_cell_ctrl.sv
// Velocity cell controller: shares one RAM port between motion-update writes and a
// count-then-stream scan of the cell, with a bounded write burst to avoid scan starvation.
module velocity_cell_ctrl
    import velocity_cell_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int PARTICLE_NUM = DEF_PARTICLE_NUM,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int WR_BURST_MAX = DEF_WR_BURST_MAX
) (
    input  logic                clk,
    input  logic                rst,
    velocity_cell_ctrl_if.slave bus,
    output state_t              o_dbg_state
);

    localparam int                    BW        = $clog2(WR_BURST_MAX + 1);
    localparam logic [ADDR_WIDTH-1:0] MAX_IDX   = ADDR_WIDTH'(PARTICLE_NUM - 1);
    localparam logic [BW-1:0]         BURST_MAX = BW'(WR_BURST_MAX);

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH-1:0] r_count;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [ADDR_WIDTH-1:0] r_out_addr;
    logic                  r_out_valid;
    logic                  r_wr_err;
    logic [BW-1:0]         r_burst;

    logic                  w_scan_need;
    logic                  w_wr_grant;
    logic                  w_scan_grant;
    logic                  w_wr_legal;
    logic                  w_wr_en;
    logic                  w_rd_fire;
    logic                  w_wr_fire;
    logic [ADDR_WIDTH-1:0] w_scan_addr;
    logic [ADDR_WIDTH-1:0] w_count_in;
    logic [ADDR_WIDTH-1:0] w_mem_addr;

    always_comb begin
        w_scan_need  = (r_state == S_RD_CNT) || (r_state == S_SCAN);
        w_wr_grant   = bus.wr_valid && !(w_scan_need && (r_burst == BURST_MAX));
        w_scan_grant = w_scan_need && !w_wr_grant;
        w_wr_legal   = (bus.wr_addr <= MAX_IDX);
        w_wr_en      = w_wr_grant && w_wr_legal;
        w_scan_addr  = (r_state == S_RD_CNT) ? '0 : r_ptr;
        w_count_in   = ADDR_WIDTH'(clamp_count(32'(bus.mem_q[ADDR_WIDTH-1:0]),
                                               32'(PARTICLE_NUM - 1)));
        // Outputs toward the RAM and requester are forced quiet while reset is held.
        w_rd_fire    = rst && w_scan_grant;
        w_wr_fire    = rst && w_wr_en;
        if (w_rd_fire) begin
            w_mem_addr = w_scan_addr;
        end else if (w_wr_fire) begin
            w_mem_addr = bus.wr_addr;
        end else begin
            w_mem_addr = r_mem_addr;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (bus.start) w_next = S_RD_CNT;
            S_RD_CNT:   if (w_scan_grant) w_next = S_WAIT_CNT;
            S_WAIT_CNT: w_next = (w_count_in == '0) ? S_DONE : S_SCAN;
            S_SCAN:     if (w_scan_grant && (r_ptr == r_count)) w_next = S_DRAIN;
            S_DRAIN:    w_next = S_DONE;
            S_DONE:     w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr       <= '0;
            r_count     <= '0;
            r_mem_addr  <= '0;
            r_out_addr  <= '0;
            r_out_valid <= 1'b0;
            r_wr_err    <= 1'b0;
            r_burst     <= '0;
        end else begin
            // Only data reads produce stream output; the count read at address 0 does not.
            r_out_valid <= w_scan_grant && (r_state == S_SCAN);
            if (w_scan_grant && (r_state == S_SCAN)) begin
                r_out_addr <= r_ptr;
            end

            if (r_state == S_WAIT_CNT) begin
                r_count <= w_count_in;
                r_ptr   <= ADDR_WIDTH'(1);
            end else if (w_scan_grant && (r_state == S_SCAN)) begin
                r_ptr <= r_ptr + 1'b1;
            end

            if (!w_scan_need || w_scan_grant) begin
                r_burst <= '0;
            end else if (w_wr_grant) begin
                r_burst <= r_burst + 1'b1;
            end

            if (w_wr_grant && !w_wr_legal) begin
                r_wr_err <= 1'b1;
            end

            if (w_scan_grant) begin
                r_mem_addr <= w_scan_addr;
            end else if (w_wr_en) begin
                r_mem_addr <= bus.wr_addr;
            end
        end
    end

    assign bus.busy           = (r_state != S_IDLE);
    assign bus.done           = (r_state == S_DONE);
    assign bus.wr_ready       = rst && w_wr_grant;
    assign bus.out_valid      = r_out_valid;
    assign bus.out_addr       = r_out_addr;
    assign bus.out_data       = bus.mem_q;
    assign bus.particle_count = r_count;
    assign bus.wr_err         = r_wr_err;
    assign bus.mem_address    = w_mem_addr;
    assign bus.mem_data       = bus.wr_data;
    assign bus.mem_rden       = w_rd_fire;
    assign bus.mem_wren       = w_wr_fire;
    assign o_dbg_state        = r_state;

endmodule

// File: tb/tb_velocity_cell_ctrl.sv
// Directed bench for velocity_cell_ctrl with a behavioural 1-cycle-latency RAM
// attached to the mem_* port.
module tb_velocity_cell_ctrl;
    import velocity_cell_ctrl_pkg::*;

    localparam int DW = 96;
    localparam int AW = 8;

    logic   clk = 1'b0;
    logic   rst = 1'b0;
    state_t dbg_state;

    velocity_cell_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    velocity_cell_ctrl #(
        .DATA_WIDTH(DW), .PARTICLE_NUM(220), .ADDR_WIDTH(AW), .WR_BURST_MAX(4)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .o_dbg_state(dbg_state)
    );

    // ---------------- clock / RAM ----------------
    always #5 clk = ~clk;

    logic [DW-1:0] ram [0:255];
    logic [DW-1:0] ram_q;
    always @(posedge clk) begin
        if (bus.mem_wren) ram[bus.mem_address] <= bus.mem_data;
        if (bus.mem_rden) ram_q <= ram[bus.mem_address];
    end
    assign bus.mem_q = ram_q;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- monitor ----------------
    logic [AW+DW-1:0] got_q[$];
    int               got_cyc_q[$];
    int               rd_cyc_q[$];
    int               done_cyc_q[$];
    int               busy_cnt    = 0;
    int               wr_busy_cnt = 0;
    int               dual_cnt    = 0;

    always @(negedge clk) begin
        if (bus.out_valid) begin
            got_q.push_back({bus.out_addr, bus.out_data});
            got_cyc_q.push_back(cyc);
        end
        if (bus.mem_rden) rd_cyc_q.push_back(cyc);
        if (bus.done) done_cyc_q.push_back(cyc);
        if (bus.busy) busy_cnt++;
        if (bus.busy && bus.mem_wren) wr_busy_cnt++;
        if (bus.mem_rden && bus.mem_wren) dual_cnt++;
    end

    // ---------------- scoreboard ----------------
    logic [AW+DW-1:0] exp_q[$];
    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_stream(input string tag, input int base);
        int i = 0;
        chk({tag, "_count"}, 128'(got_q.size() - base), 128'(exp_q.size()));
        while (exp_q.size() > 0) begin
            logic [AW+DW-1:0] e;
            e = exp_q.pop_front();
            if (base + i < got_q.size()) begin
                chk($sformatf("%s_addr%0d", tag, i), 128'(got_q[base+i][AW+DW-1:DW]), 128'(e[AW+DW-1:DW]));
                chk($sformatf("%s_data%0d", tag, i), 128'(got_q[base+i][DW-1:0]), 128'(e[DW-1:0]));
            end
            i++;
        end
    endtask

    function automatic logic [DW-1:0] pat(input int i);
        return {32'hCE11_0000 + 32'(i), 32'h5A5A_0000 ^ 32'(i * 3), 32'(i * 7 + 1)};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n = 0;
        bus.wr_valid = 1'b1;
        bus.wr_addr  = a;
        bus.wr_data  = d;
        #1;
        while (!bus.wr_ready && n < 20) begin
            tick();
            n++;
        end
        if (n == 20) chk("wr_ready_timeout", 128'(0), 128'(1));
        tick();
        bus.wr_valid = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int base_done);
        int n = 0;
        while (done_cyc_q.size() == base_done && n < 200) begin
            tick();
            n++;
        end
        chk({tag, "_done_pulses"}, 128'(done_cyc_q.size() - base_done), 128'(1));
        tick();
        tick();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int gb, db, bb, rb, wb, k;
        logic [DW-1:0] d_word;

        bus.start    = 1'b0;
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 8'd5;
        bus.wr_data  = '0;
        #1;
        chk("rst_busy",      128'(bus.busy), 128'(0));
        chk("rst_done",      128'(bus.done), 128'(0));
        chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("rst_wr_err",    128'(bus.wr_err), 128'(0));
        chk("rst_rden",      128'(bus.mem_rden), 128'(0));
        chk("rst_wren",      128'(bus.mem_wren), 128'(0));
        chk("rst_wr_ready",  128'(bus.wr_ready), 128'(0));
        chk("rst_count",     128'(bus.particle_count), 128'(0));
        chk("rst_out_addr",  128'(bus.out_addr), 128'(0));
        chk("rst_mem_addr",  128'(bus.mem_address), 128'(0));
        chk("rst_state",     128'(dbg_state), 128'(S_IDLE));
        bus.wr_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();

        // count 3 with words A,B,C
        wr_word(8'd0, 96'd3);
        for (int i = 1; i <= 3; i++) wr_word(AW'(i), pat(i));
        for (int i = 1; i <= 3; i++) exp_q.push_back({AW'(i), pat(i)});
        gb = got_q.size();
        db = done_cyc_q.size();
        do_start();
        wait_done("scan3", db);
        chk("scan3_span",  128'(got_cyc_q[gb+2] - got_cyc_q[gb]), 128'(2));
        chk("scan3_done_after_last", 128'(done_cyc_q[db] - got_cyc_q[gb+2]), 128'(1));
        check_stream("scan3", gb);
        chk("scan3_count", 128'(bus.particle_count), 128'(3));
        chk("scan3_busy_end", 128'(bus.busy), 128'(0));

        // empty cell
        wr_word(8'd0, 96'd0);
        gb = got_q.size();
        db = done_cyc_q.size();
        bb = busy_cnt;
        do_start();
        wait_done("empty", db);
        chk("empty_busy_cycles", 128'(busy_cnt - bb), 128'(3));
        chk("empty_no_out", 128'(got_q.size() - gb), 128'(0));
        chk("empty_count", 128'(bus.particle_count), 128'(0));

        // scan of 5 against a continuous writer
        wr_word(8'd0, 96'd5);
        for (int i = 1; i <= 5; i++) wr_word(AW'(i), pat(10 + i));
        for (int i = 1; i <= 5; i++) exp_q.push_back({AW'(i), pat(10 + i)});
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 8'd100;
        bus.wr_data  = pat(99);
        gb = got_q.size();
        db = done_cyc_q.size();
        bb = busy_cnt;
        rb = rd_cyc_q.size();
        wb = wr_busy_cnt;
        do_start();
        wait_done("burst", db);
        bus.wr_valid = 1'b0;
        check_stream("burst", gb);
        chk("burst_reads", 128'(rd_cyc_q.size() - rb), 128'(6));
        chk("burst_busy_cycles", 128'(busy_cnt - bb), 128'(33));
        chk("burst_busy_writes", 128'(wr_busy_cnt - wb), 128'(27));
        if (rd_cyc_q.size() - rb == 6) begin
            chk("burst_gap_cnt", 128'(rd_cyc_q[rb+1] - rd_cyc_q[rb]), 128'(6));
            for (int i = 1; i < 5; i++)
                chk($sformatf("burst_gap%0d", i), 128'(rd_cyc_q[rb+i+1] - rd_cyc_q[rb+i]), 128'(5));
        end
        chk("no_dual_access", 128'(dual_cnt), 128'(0));

        // illegal write address
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 8'd220;
        bus.wr_data  = pat(77);
        #1;
        chk("illegal_wr_ready", 128'(bus.wr_ready), 128'(1));
        chk("illegal_wren", 128'(bus.mem_wren), 128'(0));
        tick();
        bus.wr_valid = 1'b0;
        chk("illegal_wr_err", 128'(bus.wr_err), 128'(1));
        tick();
        tick();
        tick();
        chk("illegal_wr_err_sticky", 128'(bus.wr_err), 128'(1));

        // scan of 10 with a mid-scan write to 7 and to the count word
        wr_word(8'd0, 96'd10);
        for (int i = 1; i <= 10; i++) wr_word(AW'(i), pat(30 + i));
        d_word = 96'hD00D_BEEF_0000_1234_5678_9ABC;
        for (int i = 1; i <= 10; i++) exp_q.push_back({AW'(i), (i == 7) ? d_word : pat(30 + i)});
        gb = got_q.size();
        db = done_cyc_q.size();
        do_start();
        tick();
        tick();
        wr_word(8'd7, d_word);
        wr_word(8'd0, 96'd2);
        wait_done("raw", db);
        check_stream("raw", gb);
        chk("raw_count_kept", 128'(bus.particle_count), 128'(10));
        chk("raw_wr_err_kept", 128'(bus.wr_err), 128'(1));

        // reset in the middle of a scan of 6
        wr_word(8'd0, 96'd6);
        for (int i = 1; i <= 6; i++) wr_word(AW'(i), pat(50 + i));
        gb = got_q.size();
        db = done_cyc_q.size();
        do_start();
        k = 0;
        while (got_q.size() - gb < 2 && k < 40) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("abort_two_outputs", 128'(got_q.size() - gb), 128'(2));
        rst = 1'b0;
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 8'd5;
        #1;
        chk("abort_busy",      128'(bus.busy), 128'(0));
        chk("abort_out_valid", 128'(bus.out_valid), 128'(0));
        chk("abort_done",      128'(bus.done), 128'(0));
        chk("abort_rden",      128'(bus.mem_rden), 128'(0));
        chk("abort_wren",      128'(bus.mem_wren), 128'(0));
        chk("abort_wr_ready",  128'(bus.wr_ready), 128'(0));
        chk("abort_count",     128'(bus.particle_count), 128'(0));
        chk("abort_out_addr",  128'(bus.out_addr), 128'(0));
        chk("abort_mem_addr",  128'(bus.mem_address), 128'(0));
        chk("abort_wr_err",    128'(bus.wr_err), 128'(0));
        bus.wr_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        tick();
        chk("abort_no_more_out", 128'(got_q.size() - gb), 128'(2));
        chk("abort_no_done", 128'(done_cyc_q.size() - db), 128'(0));

        for (int i = 1; i <= 6; i++) exp_q.push_back({AW'(i), pat(50 + i)});
        gb = got_q.size();
        db = done_cyc_q.size();
        do_start();
        wait_done("rescan", db);
        check_stream("rescan", gb);
        chk("rescan_count", 128'(bus.particle_count), 128'(6));
        chk("final_no_dual", 128'(dual_cnt), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
